// File: rtl/mem_line_ctrl.sv
// Line-sized main-memory controller shared by the icache and dcache.
// Round-robin grant, fixed latency, one registered ack pulse per line.
module mem_line_ctrl #(
   parameter int LINE_BYTES  = 64,
   parameter int LINE_BITS   = LINE_BYTES * 8,
   parameter int MEM_LINES   = 1024,
   parameter int MEM_LATENCY = 5,
   parameter int ADDR_SIZE   = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ic_req_i,
   input  logic [ADDR_SIZE-1:0] ic_addr_i,
   output logic                 ic_ack_o,
   output logic [LINE_BITS-1:0] ic_rdata_o,
   input  logic                 dc_req_i,
   input  logic                 dc_rd_wr_i,
   input  logic [ADDR_SIZE-1:0] dc_addr_i,
   input  logic [LINE_BITS-1:0] dc_wdata_i,
   output logic                 dc_ack_o,
   output logic [LINE_BITS-1:0] dc_rdata_o,
   output logic                 busy_o
);

   localparam int OFF = $clog2(LINE_BYTES);
   localparam int IDX = $clog2(MEM_LINES);
   localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nx;
   logic                grant;
   logic                grant_dc;
   logic                fire;
   logic                last_dc;
   logic                sel_dc;
   logic                rd_wr;
   logic [IDX-1:0]      idx;
   logic [LINE_BITS-1:0] wdata;
   logic [LINE_BITS-1:0] mem [MEM_LINES];
   logic                unused_addr;

   // offset and alias bits of the addresses never select anything
   assign unused_addr = ^{ic_addr_i, dc_addr_i};

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      grant    = 1'b0;
      grant_dc = 1'b0;
      fire     = 1'b0;
      unique case (state)
         IDLE: begin
            if (ic_req_i || dc_req_i) begin
               grant    = 1'b1;
               grant_dc = dc_req_i && (!ic_req_i || !last_dc);
               cnt_nx   = CNT_LOAD;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               fire     = 1'b1;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_dc    <= 1'b0;
         sel_dc     <= 1'b0;
         rd_wr      <= 1'b0;
         idx        <= '0;
         ic_ack_o   <= 1'b0;
         dc_ack_o   <= 1'b0;
         busy_o     <= 1'b0;
         ic_rdata_o <= '0;
         dc_rdata_o <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         busy_o   <= (state_nx != IDLE);
         ic_ack_o <= fire && !sel_dc;
         dc_ack_o <= fire && sel_dc;
         if (grant) begin
            sel_dc  <= grant_dc;
            last_dc <= grant_dc;
            rd_wr   <= grant_dc && dc_rd_wr_i;
            idx     <= grant_dc ? dc_addr_i[OFF+IDX-1:OFF]
                                : ic_addr_i[OFF+IDX-1:OFF];
         end
         if (fire && !rd_wr) begin
            if (sel_dc) dc_rdata_o <= mem[idx];
            else        ic_rdata_o <= mem[idx];
         end
      end
   end

   // wide payload needs no reset: it is only used after a fresh grant
   always_ff @(posedge clk) begin
      if (grant && grant_dc) wdata <= dc_wdata_i;
   end

   always_ff @(posedge clk) begin
      if (reset_n && fire && rd_wr) mem[idx] <= wdata;
   end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl: vector table, random traffic
// against a line-array model, and hand-written arbitration/reset/burst cases.
module tb_mem_line_ctrl;

   localparam int LB    = 512;
   localparam int AW    = 32;
   localparam int LAT   = 5;
   localparam int LINES = 1024;
   localparam int FL    = 1;
   localparam int FLINES = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          ic_req, dc_req, dc_rd_wr;
   logic [AW-1:0] ic_addr, dc_addr;
   logic [LB-1:0] dc_wdata;
   logic          ic_ack, dc_ack, busy;
   logic [LB-1:0] ic_rdata, dc_rdata;

   logic          f_ic_req, f_dc_req, f_dc_rd_wr;
   logic [AW-1:0] f_ic_addr, f_dc_addr;
   logic [LB-1:0] f_dc_wdata;
   logic          f_ic_ack, f_dc_ack, f_busy;
   logic [LB-1:0] f_ic_rdata, f_dc_rdata;

   mem_line_ctrl #(
      .LINE_BYTES(64), .MEM_LINES(LINES),
      .MEM_LATENCY(LAT), .ADDR_SIZE(AW)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .ic_req_i(ic_req), .ic_addr_i(ic_addr),
      .ic_ack_o(ic_ack), .ic_rdata_o(ic_rdata),
      .dc_req_i(dc_req), .dc_rd_wr_i(dc_rd_wr),
      .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
      .dc_ack_o(dc_ack), .dc_rdata_o(dc_rdata),
      .busy_o(busy)
   );

   mem_line_ctrl #(
      .LINE_BYTES(64), .MEM_LINES(FLINES),
      .MEM_LATENCY(FL), .ADDR_SIZE(AW)
   ) u_fast (
      .clk(clk), .reset_n(reset_n),
      .ic_req_i(f_ic_req), .ic_addr_i(f_ic_addr),
      .ic_ack_o(f_ic_ack), .ic_rdata_o(f_ic_rdata),
      .dc_req_i(f_dc_req), .dc_rd_wr_i(f_dc_rd_wr),
      .dc_addr_i(f_dc_addr), .dc_wdata_i(f_dc_wdata),
      .dc_ack_o(f_dc_ack), .dc_rdata_o(f_dc_rdata),
      .busy_o(f_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [LB-1:0] model [LINES];
   logic [LB-1:0] fdata [8];

   typedef struct {
      bit            dc;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LB-1:0] wdata;
      logic [LB-1:0] exp;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [LB-1:0] act,
                      input logic [LB-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LB-1:0] rnd_line();
      logic [LB-1:0] v;
      for (int k = 0; k < LB / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic int line_of(input logic [AW-1:0] a);
      return int'((a / 64) % LINES);
   endfunction

   // One request on the main instance; inputs are scribbled after the
   // grant to confirm the controller works from its latched copy.
   task automatic do_req(input bit dc, input bit wr, input logic [AW-1:0] addr,
                         input logic [LB-1:0] wd, output logic [LB-1:0] rd,
                         output int lat);
      int  e;
      bit  bad;
      e   = 0;
      bad = 1'b0;
      lat = -1;
      rd  = '0;
      @(negedge clk);
      if (dc) begin
         dc_req = 1'b1; dc_rd_wr = wr; dc_addr = addr; dc_wdata = wd;
      end else begin
         ic_req = 1'b1; ic_addr = addr;
      end
      while (lat < 0 && e < 40) begin
         @(posedge clk); #1;
         if (e == 1) begin
            chk("busy_wait", busy, 1);
            ic_addr = ~ic_addr; dc_addr = ~dc_addr;
            dc_wdata = ~dc_wdata; dc_rd_wr = ~dc_rd_wr;
         end
         if (dc ? dc_ack : ic_ack) begin
            lat = e;
            rd  = dc ? dc_rdata : ic_rdata;
         end
         if (dc ? ic_ack : dc_ack) bad = 1'b1;
         e++;
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      chk("wrong_port_ack", bad, 0);
      @(posedge clk); #1;
      chk("ack_one_cycle", {ic_ack, dc_ack}, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic fast_burst(input bit wr);
      int acks, e, first, last;
      acks = 0; e = 0; first = -1; last = -1;
      @(negedge clk);
      if (wr) begin
         f_dc_req = 1'b1; f_dc_rd_wr = 1'b1;
         f_dc_addr = 32'h0; f_dc_wdata = fdata[0];
      end else begin
         f_ic_req = 1'b1; f_ic_addr = 32'h0;
      end
      while (acks < 8 && e < 100) begin
         @(posedge clk); #1;
         if (wr ? f_dc_ack : f_ic_ack) begin
            if (!wr) chk("fast_rdata", f_ic_rdata, fdata[acks]);
            if (acks == 0) first = e;
            last = e;
            acks++;
            if (acks < 8) begin
               f_dc_addr  = AW'(acks * 64 + acks * 32'h10000);
               f_ic_addr  = f_dc_addr;
               f_dc_wdata = fdata[acks];
            end else begin
               f_dc_req = 1'b0;
               f_ic_req = 1'b0;
            end
         end
         e++;
      end
      f_dc_req = 1'b0;
      f_ic_req = 1'b0;
      chk("fast_acks", acks, 8);
      chk("fast_first_ack", first, FL);
      chk("fast_last_ack", last, 7 * (FL + 2) + FL);
   endtask

   initial begin
      logic [LB-1:0] rd;
      logic [LB-1:0] a5, h1234, c3, nw;
      logic [AW-1:0] addr;
      int            lat, ln, op, e, ic_e, dc_e;
      bit            both, stray;

      a5    = {64{8'hA5}};
      h1234 = {32{16'h1234}};
      c3    = {64{8'hC3}};
      vt[0] = '{1, 1, 32'h0000_00C0, a5, '0};
      vt[1] = '{1, 0, 32'h0000_00C0, '0, a5};
      vt[2] = '{1, 1, 32'h0000_0040, h1234, '0};
      vt[3] = '{0, 0, 32'h0000_0040, '0, h1234};
      vt[4] = '{0, 0, 32'h0000_0040 + LINES * 64, '0, h1234};
      vt[5] = '{1, 1, 32'h0000_0000, c3, '0};
      vt[6] = '{1, 0, 32'h0000_003F, '0, c3};
      vt[7] = '{0, 0, 32'h0001_0000, '0, c3};

      reset_n = 1'b0;
      ic_req = 0; dc_req = 0; dc_rd_wr = 0;
      ic_addr = '0; dc_addr = '0; dc_wdata = '0;
      f_ic_req = 0; f_dc_req = 0; f_dc_rd_wr = 0;
      f_ic_addr = '0; f_dc_addr = '0; f_dc_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_acks", {ic_ack, dc_ack}, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ic_rdata", ic_rdata, 0);
      chk("reset_dc_rdata", dc_rdata, 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_req(vt[i].dc, vt[i].wr, vt[i].addr, vt[i].wdata, rd, lat);
         chk($sformatf("vec%0d_latency", i), lat, LAT);
         if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
         else model[line_of(vt[i].addr)] = vt[i].wdata;
      end

      for (int i = 0; i < 16; i++) begin
         nw   = rnd_line();
         addr = AW'(($urandom() & 32'hFFFF_0000) | (i * 64) | $urandom_range(0, 63));
         do_req(1, 1, addr, nw, rd, lat);
         model[line_of(addr)] = nw;
      end
      for (int i = 0; i < 60; i++) begin
         ln   = $urandom_range(0, 15);
         addr = AW'(($urandom() & 32'hFFFF_0000) | (ln * 64) | $urandom_range(0, 63));
         op   = $urandom_range(0, 2);
         nw   = rnd_line();
         do_req(op != 0, op == 2, addr, nw, rd, lat);
         chk("rand_latency", lat, LAT);
         if (op == 2) model[line_of(addr)] = nw;
         else chk("rand_rdata", rd, model[line_of(addr)]);
      end

      // reset in the middle of a write: no ack, line keeps old contents
      @(negedge clk);
      dc_req = 1; dc_rd_wr = 1; dc_addr = 32'h140; dc_wdata = ~model[5];
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      dc_req  = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_acks", {ic_ack, dc_ack}, 0);
      chk("abort_dc_rdata", dc_rdata, 0);
      reset_n = 1'b1;
      stray = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ic_ack || dc_ack || busy) stray = 1'b1;
      end
      chk("abort_no_ack", stray, 0);

      // both ports at once right after reset: dcache wins first
      @(negedge clk);
      ic_req = 1; ic_addr = 32'h40;
      dc_req = 1; dc_rd_wr = 0; dc_addr = 32'hC0;
      e = 0; ic_e = -1; dc_e = -1; both = 1'b0;
      while ((ic_e < 0 || dc_e < 0) && e < 60) begin
         @(posedge clk); #1;
         if (ic_ack && dc_ack) both = 1'b1;
         if (dc_ack) begin
            dc_e = e; chk("arb_dc_rdata", dc_rdata, model[3]); dc_req = 0;
         end
         if (ic_ack) begin
            ic_e = e; chk("arb_ic_rdata", ic_rdata, model[1]); ic_req = 0;
         end
         e++;
      end
      ic_req = 0; dc_req = 0;
      chk("arb_never_both", both, 0);
      chk("arb_dc_ack_edge", dc_e, LAT);
      chk("arb_ic_ack_edge", ic_e, LAT + LAT + 2);

      do_req(1, 0, 32'h140, '0, rd, lat);
      chk("abort_line_kept", rd, model[5]);

      for (int i = 0; i < 8; i++) fdata[i] = rnd_line();
      fast_burst(1'b1);
      @(negedge clk);
      @(negedge clk);
      fast_burst(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
